// File: rtl/fp_add_arbiter_pkg.sv
// Shared types and constants for the floating-point adder arbiter.
// Field widths describe operand words: bit 0 sign, next 6 exponent, top 25 mantissa.
package fp_arb_pkg;

    localparam int SIGN_W   = 1;
    localparam int EXP_W    = 6;
    localparam int MANT_W   = 25;
    localparam int WORD_W   = SIGN_W + EXP_W + MANT_W;
    localparam int STATUS_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    localparam logic [STATUS_W-1:0] EXACT     = 4'd0;
    localparam logic [STATUS_W-1:0] OVERFLOW  = 4'd1;
    localparam logic [STATUS_W-1:0] UNDERFLOW = 4'd2;
    localparam logic [STATUS_W-1:0] INEXACT   = 4'd3;
    localparam logic [STATUS_W-1:0] TIMEOUT   = 4'd4;

endpackage

// File: rtl/fp_add_arbiter_if.sv
// Request/response and shared-adder signals of the adder arbiter.
// slave = arbiter side, master = requesters plus adder side.
interface fp_add_arbiter_if #(
    parameter int N_REQ = 4
);
    import fp_arb_pkg::*;

    logic [N_REQ-1:0]        req_valid;
    logic [WORD_W*N_REQ-1:0] req_op_a;
    logic [WORD_W*N_REQ-1:0] req_op_b;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        resp_valid;
    logic [WORD_W-1:0]       resp_data;
    logic [STATUS_W-1:0]     resp_status;
    logic [WORD_W-1:0]       fpu_op_a;
    logic [WORD_W-1:0]       fpu_op_b;
    logic                    fpu_start;
    logic                    fpu_done;
    logic [WORD_W-1:0]       fpu_result;
    logic [STATUS_W-1:0]     fpu_status;
    logic                    busy;

    modport slave (
        input  req_valid, req_op_a, req_op_b, fpu_done, fpu_result, fpu_status,
        output req_ready, resp_valid, resp_data, resp_status,
        output fpu_op_a, fpu_op_b, fpu_start, busy
    );

    modport master (
        output req_valid, req_op_a, req_op_b, fpu_done, fpu_result, fpu_status,
        input  req_ready, resp_valid, resp_data, resp_status,
        input  fpu_op_a, fpu_op_b, fpu_start, busy
    );

endinterface

// File: rtl/fp_add_arbiter_rr_arbiter.sv
// Round-robin picker: searches from ptr+1 upward (wrapping) for the first request.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = IDX_W'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one floating-point adder among N_REQ requesters with round-robin arbitration.
// Optional WAIT watchdog enabled by defining FP_ARB_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no operation; accept round-robin winner of req_valid
// ISSUE   | operands on adder bus, fpu_start pulsed
// WAIT    | waiting for fpu_done (or watchdog expiry)
// RESPOND | resp_valid strobe to the granted requester
module fp_add_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic          clock_100kHz,
    input logic          reset,
    fp_add_arbiter_if.slave bus
);
    import fp_arb_pkg::*;

    localparam int IDX_W = $clog2(N_REQ);

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     lat_idx;
    logic [IDX_W-1:0]     win_idx;
    logic [N_REQ-1:0]     win_grant;
    logic                 win_any;
    logic [WORD_W-1:0]    op_a_q, op_b_q, res_q;
    logic [STATUS_W-1:0]  stat_q;
    logic                 take;
    logic                 fin;
    logic [WORD_W-1:0]    fin_data;
    logic [STATUS_W-1:0]  fin_stat;
    logic                 expired;

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (win_grant),
        .idx   (win_idx),
        .any   (win_any)
    );

`ifdef FP_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] tmr;

    // Loaded in ISSUE so it reads zero in the TIMEOUT_CYCLES-th WAIT cycle
    always_ff @(posedge clock_100kHz) begin
        if (!reset) begin
            tmr <= '0;
        end else if (state == ISSUE) begin
            tmr <= TMR_W'(TIMEOUT_CYCLES - 1);
        end else if (state == WAIT && tmr != '0) begin
            tmr <= tmr - 1'b1;
        end
    end

    assign expired = (tmr == '0);
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_nxt       = state;
        take            = 1'b0;
        fin             = 1'b0;
        fin_data        = bus.fpu_result;
        fin_stat        = bus.fpu_status;
        bus.req_ready   = '0;
        bus.resp_valid  = '0;
        bus.fpu_start   = 1'b0;
        bus.busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (reset) begin
                    bus.req_ready = win_grant;
                end
                if (win_any) begin
                    take      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                bus.fpu_start = 1'b1;
                state_nxt     = WAIT;
            end
            WAIT: begin
                // Completion takes priority over a watchdog expiring in the same cycle
                if (bus.fpu_done) begin
                    fin       = 1'b1;
                    state_nxt = RESPOND;
                end else if (expired) begin
                    fin       = 1'b1;
                    fin_data  = '0;
                    fin_stat  = TIMEOUT;
                    state_nxt = RESPOND;
                end
            end
            RESPOND: begin
                bus.resp_valid = N_REQ'(1) << lat_idx;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_100kHz) begin
        if (!reset) begin
            state   <= IDLE;
            ptr     <= IDX_W'(N_REQ - 1);
            lat_idx <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            stat_q  <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                ptr     <= win_idx;
                lat_idx <= win_idx;
                op_a_q  <= bus.req_op_a[WORD_W*win_idx +: WORD_W];
                op_b_q  <= bus.req_op_b[WORD_W*win_idx +: WORD_W];
            end
            if (fin) begin
                res_q  <= fin_data;
                stat_q <= fin_stat;
            end
        end
    end

    assign bus.fpu_op_a    = op_a_q;
    assign bus.fpu_op_b    = op_b_q;
    assign bus.resp_data   = res_q;
    assign bus.resp_status = stat_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Scoreboard bench for fp_add_arbiter: random requesters and adder model, monitor checks.
// Define FP_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_fp_add_arbiter;
    import fp_arb_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 255;

    logic clock_100kHz = 1'b0;
    logic reset        = 1'b0;
    always #5 clock_100kHz = ~clock_100kHz;

    fp_add_arbiter_if #(.N_REQ(N)) bus ();

    fp_add_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clock_100kHz (clock_100kHz),
        .reset        (reset),
        .bus          (bus)
    );

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic [3:0]  st;
        int          cyc;
    } resp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    resp_t       resp_q[$];
    int          gorder[$];
    bit          inflight = 0;
    int          grant_cyc = 0;
    int          grant_idx = 0;
    int          last_g = N - 1;
    logic [31:0] exp_a = '0, exp_b = '0;
    logic [31:0] held_d = '0;
    logic [3:0]  held_s = '0;
    int          grants_per[N];
    int          n_grant = 0, n_resp = 0;
    int          busy_run = 0, last_busy_len = 0;

    // adder model controls
    int          next_delay = -1;
    bit          force_en = 0;
    logic [31:0] force_res = '0;
    logic [3:0]  force_st = '0;
    bit          spurious_en = 0;

    // requester state
    logic [N-1:0] drv_v = '0;
    logic [31:0]  drv_a[N], drv_b[N];
    bit           refill = 0;
    int           drop_pct = 0, new_pct = 0;

    always @(posedge clock_100kHz) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // monitor / scoreboard
    initial begin
        int          w;
        logic [N-1:0] exp_rdy;
        resp_t       e;
        bit          rst_prev;
        rst_prev = 1'b1;
        forever begin
            @(negedge clock_100kHz);
            if (!reset) begin
                chk("ready_in_reset", bus.req_ready, '0);
                if (!rst_prev) begin
                    chk("busy_rst", bus.busy, 0);
                    chk("resp_valid_rst", bus.resp_valid, 0);
                    chk("fpu_start_rst", bus.fpu_start, 0);
                    chk("resp_data_rst", bus.resp_data, 0);
                    chk("resp_status_rst", bus.resp_status, 0);
                    chk("fpu_op_a_rst", bus.fpu_op_a, 0);
                end
                inflight = 0;
                last_g   = N - 1;
                resp_q.delete();
                held_d   = '0;
                held_s   = '0;
                busy_run = 0;
            end else begin
                w       = inflight ? -1 : rr_pick(bus.req_valid, last_g);
                exp_rdy = (w < 0) ? '0 : (N'(1) << w);
                chk("req_ready", bus.req_ready, exp_rdy);
                chk("busy", bus.busy, inflight);
                chk("fpu_start", bus.fpu_start, (inflight && cyc == grant_cyc + 1));
                if (inflight) begin
                    chk("fpu_op_a", bus.fpu_op_a, exp_a);
                    chk("fpu_op_b", bus.fpu_op_b, exp_b);
                end
                if (bus.busy) busy_run++;
                else if (busy_run > 0) begin
                    last_busy_len = busy_run;
                    busy_run = 0;
                end
                if (bus.resp_valid != '0) begin
                    n_resp++;
                    if (resp_q.size() == 0) begin
                        chk("unexpected_resp", bus.resp_valid, '0);
                    end else begin
                        e = resp_q.pop_front();
                        chk("resp_valid", bus.resp_valid, N'(1) << e.idx);
                        chk("resp_data", bus.resp_data, e.data);
                        chk("resp_status", bus.resp_status, e.st);
                        chk("resp_cycle", cyc, e.cyc);
                        held_d = e.data;
                        held_s = e.st;
                    end
                    inflight = 0;
                end else begin
                    if (resp_q.size() != 0 && resp_q[0].cyc <= cyc) begin
                        e = resp_q.pop_front();
                        chk("missing_resp", 0, 1);
                        inflight = 0;
                    end
                    chk("resp_data_hold", bus.resp_data, held_d);
                    chk("resp_status_hold", bus.resp_status, held_s);
                end
                if (w >= 0) begin
                    inflight  = 1;
                    grant_cyc = cyc;
                    grant_idx = w;
                    last_g    = w;
                    exp_a     = bus.req_op_a[32*w +: 32];
                    exp_b     = bus.req_op_b[32*w +: 32];
                    grants_per[w]++;
                    n_grant++;
                    gorder.push_back(w);
                end
            end
            rst_prev = reset;
        end
    end

    // shared adder model
    initial begin
        bit armed;
        int d, scyc;
        resp_t r;
        armed = 0; d = 0; scyc = 0;
        bus.fpu_done   = 1'b0;
        bus.fpu_result = '0;
        bus.fpu_status = '0;
        forever begin
            @(negedge clock_100kHz);
            if (!reset) begin
                armed = 0;
            end else if (bus.fpu_start && !armed) begin
                scyc = cyc;
                d = (next_delay < 0) ? int'($urandom_range(1, 5)) : next_delay;
                if (d == 0) begin
`ifdef FP_ARB_TIMEOUT_EN
                    r.idx = grant_idx; r.data = '0; r.st = TIMEOUT; r.cyc = scyc + TMO + 1;
                    resp_q.push_back(r);
`endif
                end else begin
                    armed = 1;
                end
            end
            @(posedge clock_100kHz);
            #1;
            if (armed && cyc == scyc + d) begin
                r.idx  = grant_idx;
                r.data = force_en ? force_res : 32'($urandom);
                r.st   = force_en ? force_st : 4'($urandom_range(0, 3));
                r.cyc  = cyc + 1;
                bus.fpu_done   = 1'b1;
                bus.fpu_result = r.data;
                bus.fpu_status = r.st;
                resp_q.push_back(r);
                armed = 0;
            end else begin
                bus.fpu_done   = (!armed && spurious_en && $urandom_range(0, 7) == 0);
                bus.fpu_result = 32'($urandom);
                bus.fpu_status = 4'($urandom);
            end
        end
    end

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.req_op_a[32*i +: 32] = drv_a[i];
            bus.req_op_b[32*i +: 32] = drv_b[i];
        end
        bus.req_valid = drv_v;
    endtask

    task automatic new_ops(input int i);
        drv_a[i] = 32'($urandom);
        drv_b[i] = 32'($urandom);
    endtask

    task automatic step();
        logic [N-1:0] acc;
        @(negedge clock_100kHz);
        acc = bus.req_ready;
        @(posedge clock_100kHz);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && drv_v[i]) begin
                if (refill) new_ops(i);
                else drv_v[i] = 1'b0;
            end else if (drv_v[i] && $urandom_range(0, 99) < drop_pct) begin
                drv_v[i] = 1'b0;
            end else if (!drv_v[i] && $urandom_range(0, 99) < new_pct) begin
                drv_v[i] = 1'b1;
                new_ops(i);
            end
        end
        apply();
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while ((inflight || drv_v != '0) && n < limit) begin
            step();
            n++;
        end
        chk(name, (n < limit), 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
    endtask

    initial begin
        int n, g0, r0, g3;
        for (int i = 0; i < N; i++) begin
            drv_a[i] = '0; drv_b[i] = '0; grants_per[i] = 0;
        end
        apply();
        repeat (3) step();
        reset = 1'b1;
        step();

        // single request, minimum latency, fixed result
        next_delay = 1; force_en = 1; force_res = 32'h4300_0000; force_st = EXACT;
        drv_a[0] = 32'h4200_0000; drv_b[0] = 32'h4100_0000; drv_v = 4'b0001;
        apply();
        drain("single_drain", 20);
        chk("single_data", bus.resp_data, 32'h4300_0000);
        chk("single_status", bus.resp_status, 0);

        // all four continuously requesting
        do_reset();
        force_en = 0; next_delay = -1; refill = 1;
        for (int i = 0; i < N; i++) new_ops(i);
        drv_v = 4'hF; apply();
        gorder.delete(); g0 = n_grant; r0 = n_resp;
        n = 0;
        while (gorder.size() < 5 && n < 200) begin step(); n++; end
        refill = 0;
        drain("rr_drain", 200);
        chk("rr_got5", (gorder.size() >= 5), 1);
        if (gorder.size() >= 5) begin
            chk("rr_order0", gorder[0], 0);
            chk("rr_order1", gorder[1], 1);
            chk("rr_order2", gorder[2], 2);
            chk("rr_order3", gorder[3], 3);
            chk("rr_order4", gorder[4], 0);
        end
        chk("rr_resp_per_grant", n_resp - r0, n_grant - g0);

        // slow adder with overflow status, another requester pending
        next_delay = 10; force_en = 1; force_res = 32'($urandom); force_st = OVERFLOW;
        new_ops(0); new_ops(2); drv_v = 4'b0101; apply();
        drain("slow_drain", 100);
        chk("slow_busy_len", last_busy_len, 12);
        chk("slow_status", bus.resp_status, 1);

        // reset while waiting on the adder
        force_en = 0; next_delay = 50;
        new_ops(2); drv_v = 4'b0100; apply();
        n = 0;
        while (!(inflight && cyc >= grant_cyc + 4) && n < 50) begin step(); n++; end
        chk("reset_reach_wait", (n < 50), 1);
        r0 = n_resp;
        do_reset();
        step();
        chk("reset_no_resp", n_resp - r0, 0);
        next_delay = 2;
        new_ops(0); new_ops(2); drv_v = 4'b0101; apply();
        gorder.delete();
        drain("reset_drain", 50);
        chk("reset_first_grant", (gorder.size() > 0) ? gorder[0] : -1, 0);

        // withdrawn request is never served
        next_delay = 6; g3 = grants_per[3];
        new_ops(0); drv_v = 4'b0001; apply();
        step(); step();
        drv_v[3] = 1'b1; new_ops(3); apply();
        step(); step();
        drv_v[3] = 1'b0; apply();
        drain("drop_drain", 50);
        chk("drop_no_grant", grants_per[3], g3);

        // random traffic with spurious done pulses
        next_delay = -1; spurious_en = 1; new_pct = 30; drop_pct = 5;
        repeat (400) step();
        new_pct = 0; drop_pct = 0; spurious_en = 0;
        drain("random_drain", 100);
        for (int i = 0; i < N; i++) chk("no_starve", (grants_per[i] > 0), 1);

`ifdef FP_ARB_TIMEOUT_EN
        next_delay = 0;
        new_ops(1); drv_v = 4'b0010; apply();
        drain("timeout_drain", 400);
        chk("timeout_status", bus.resp_status, 4);
        chk("timeout_data", bus.resp_data, 0);
        next_delay = TMO; force_en = 1; force_res = 32'h3F80_0001; force_st = INEXACT;
        new_ops(1); drv_v = 4'b0010; apply();
        drain("expiry_done_drain", 400);
        chk("expiry_done_status", bus.resp_status, 3);
        chk("expiry_done_data", bus.resp_data, 32'h3F80_0001);
        force_en = 0;
`endif

        step();
        chk("scoreboard_empty", resp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_add_arbiter.md
FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters sharing one floating-point adder (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum WAIT-state cycles before a timeout response.
REQ-003 clock_100kHz  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-low reset.
REQ-005 req_valid  input  N_REQ  SHALL carry per-requester operation requests.
REQ-006 req_op_a, req_op_b  input  32*N_REQ  SHALL carry operands; requester i owns flat bits 32*i..32*i+31, lowest index = sign, next 6 = exponent, last 25 = mantissa.
REQ-007 req_ready  output  N_REQ  SHALL be a one-hot, one-cycle accept strobe.
REQ-008 resp_valid  output  N_REQ  SHALL be a one-hot, one-cycle response strobe to the granted requester.
REQ-009 resp_data  output  32 and resp_status  output  4  SHALL carry the result and status (0 exact, 1 overflow, 2 underflow, 3 inexact, 4 timeout).
REQ-010 fpu_op_a, fpu_op_b  output  32  SHALL drive the shared adder operands.
REQ-011 fpu_start  output  1  SHALL pulse one cycle to launch the adder.
REQ-012 fpu_done  input  1, fpu_result  input  32, fpu_status  input  4  SHALL return adder completion, result and status.
REQ-013 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-014 FSM SHALL have states IDLE, ISSUE, WAIT, RESPOND: IDLE->ISSUE on grant, ISSUE->WAIT unconditionally, WAIT->RESPOND on fpu_done or timeout, RESPOND->IDLE unconditionally.
REQ-015 In IDLE with any req_valid high, req_ready SHALL assert combinationally for the round-robin winner, and its operands and index SHALL be latched on that edge.
REQ-016 Round-robin search SHALL start at (last granted index + 1) mod N_REQ; pointer SHALL update only on a grant.
REQ-017 req_ready SHALL be low outside IDLE; requests then remain pending without side effects.
REQ-018 fpu_op_a/fpu_op_b SHALL hold the latched operands from ISSUE through WAIT; fpu_start SHALL be high only in ISSUE.
REQ-019 fpu_done SHALL be ignored outside WAIT.
REQ-020 On fpu_done in WAIT, fpu_result and fpu_status SHALL be latched; resp_valid SHALL assert the following cycle (RESPOND).
REQ-021 resp_data/resp_status SHALL hold their last value until the next RESPOND.
REQ-022 Minimum latency SHALL be: accept edge T, fpu_start in cycle T+1, resp_valid in cycle T+3 when fpu_done is high in cycle T+2.
REQ-023 A requester dropping req_valid before its req_ready SHALL cause no grant and no response.

Reset
REQ-024 With reset low at a clock edge: state=IDLE, pointer=N_REQ-1 (requester 0 wins first), all outputs 0, latched operands/results 0.
REQ-025 Reset during ISSUE/WAIT/RESPOND SHALL abort the operation with no resp_valid issued.

Configuration
REQ-026 With FP_ARB_TIMEOUT_EN defined, a WAIT cycle counter SHALL force RESPOND with resp_data=0, resp_status=4 after TIMEOUT_CYCLES cycles without fpu_done; fpu_done in the expiry cycle SHALL win.
REQ-027 Without FP_ARB_TIMEOUT_EN, no counter SHALL exist and WAIT SHALL persist until fpu_done.

Structure
REQ-028 Package fp_arb_pkg SHALL hold state_t, status constants (EXACT=0, OVERFLOW=1, UNDERFLOW=2, INEXACT=3, TIMEOUT=4) and field widths (sign 1, exponent 6, mantissa 25).
REQ-029 Sub-module rr_arbiter SHALL implement the round-robin picker (request vector, pointer -> one-hot grant, index).

Verification
REQ-030 Single request: req_valid=0001, op_a=32'h4200_0000, op_b=32'h4100_0000, fpu_done one cycle after start with result 32'h4300_0000, status 0 -> resp_valid=0001 at T+3, resp_data=32'h4300_0000.
REQ-031 All four requesting continuously -> grant order 0,1,2,3,0; exactly one resp per grant, no requester starved.
REQ-032 fpu_done delayed 10 cycles, fpu_status=1 -> busy high 12 cycles, resp_status=1, req_ready low meanwhile.
REQ-033 With FP_ARB_TIMEOUT_EN, fpu_done never asserted -> resp_status=4, resp_data=0 after 255 WAIT cycles; done on cycle 255 -> normal status.
REQ-034 Reset asserted in WAIT -> no resp_valid, next grant goes to requester 0.
